cnn_3d_stage_sequencer: RTL and testbench
=========================================

// Module: cnn_3d_stage_sequencer
// PURPOSE
//   Parametrised pipeline controller for the 3D CNN datapath (conv -> pool -> fc -> ...).
//   Launches NUM_STAGES compute units in order with one-cycle start pulses and waits on
//   each unit's done. Latches the last stage's result vector and counts completed frames.
//   Supports abort and an optional per-stage watchdog. Replaces the fixed 3-stage top FSM.
// PARAMETERS
//   NUM_STAGES     3     number of chained compute stages (>=1)
//   DATA_WIDTH     16    bits per result element, signed
//   FC_OUTPUTS     2     number of result elements latched from the final stage
//   FRAME_CNT_W    8     width of completed-frame counter
//   TIMEOUT_CYCLES 1024  watchdog limit in WAIT cycles (used only with CNN_STAGE_TIMEOUT_EN)
// PORTS
//   clk           in   1                        clock, all logic on rising edge
//   reset         in   1                        synchronous, active-high
//   start         in   1                        begin a frame (sampled in IDLE/ERROR only)
//   abort         in   1                        cancel frame in progress
//   stage_start   out  NUM_STAGES               one-hot, one-cycle launch pulse per stage
//   stage_done    in   NUM_STAGES               per-stage completion, bit i owned by stage i
//   fc_result     in   FC_OUTPUTS*DATA_WIDTH    final-stage results, element k at [k*DW +: DW]
//   final_output  out  FC_OUTPUTS*DATA_WIDTH    latched results, same packing
//   stage_idx     out  max(1,$clog2(NUM_STAGES)) index of stage being launched/awaited
//   busy          out  1                        high in LAUNCH, WAIT, COMPLETE
//   done          out  1                        one-cycle pulse at frame completion
//   frame_count   out  FRAME_CNT_W              completed frames, wraps to 0
//   error         out  1                        sticky watchdog flag
// BEHAVIOUR
//   - Reset: state IDLE; stage_start, final_output, stage_idx, done, frame_count, error,
//     timer all 0. Reset asserted mid-frame discards the frame; no done pulse.
//   - States: IDLE, LAUNCH, WAIT, COMPLETE, ERROR. All outputs registered.
//   - IDLE: start=1 & abort=0 -> LAUNCH, stage_idx<=0.
//   - LAUNCH: stage_start[stage_idx]=1 for this cycle only; -> WAIT.
//   - WAIT: stage_done[stage_idx]=1 -> stage_idx==NUM_STAGES-1 ? COMPLETE : (stage_idx+1, LAUNCH).
//     On the COMPLETE transition, fc_result is captured into final_output on that edge.
//     stage_done bits of other stages are ignored. A done held high from a previous
//     stage does not skip a stage: only the current index is checked, and only in WAIT.
//   - COMPLETE: done=1 for one cycle; frame_count+1 mod 2^FRAME_CNT_W; -> IDLE.
//   - start seen in LAUNCH/WAIT/COMPLETE is ignored; no queuing.
//   - abort in LAUNCH/WAIT: -> IDLE next cycle. stage_start is not asserted that cycle.
//     final_output and frame_count are retained. abort beats stage_done on the same cycle.
//     abort in COMPLETE is ignored; the frame counts.
//   - abort & start together in IDLE: stay IDLE.
//   - Latency: done pulses 2*NUM_STAGES+1 cycles after the edge that sampled start,
//     when every stage_done is high on the first WAIT cycle.
//   - Back-to-back: start may be high in the cycle after done; the next frame launches.
// CONFIGURATION
//   CNN_STAGE_TIMEOUT_EN defined:
//     - Timer clears in LAUNCH and increments each WAIT cycle without stage_done.
//     - Timer reaching TIMEOUT_CYCLES -> ERROR; error<=1; stage_idx holds the failing stage.
//     - ERROR: busy=0. start -> error<=0, stage_idx<=0, LAUNCH. abort has no effect in ERROR.
//   Not defined: no timer, WAIT waits indefinitely, error tied 0, ERROR unreachable.
// TESTING
//   1 NUM_STAGES=3; start; each stage_done on first WAIT cycle; fc_result={16'sd-5,16'sd7}
//     -> stage_start pulses 001,010,100 one cycle each; done 7 cycles after start edge;
//     final_output={-5,7}; frame_count=1.
//   2 abort at stage_idx=1 in WAIT while stage_done[1]=1 -> IDLE; no done; stage_start[2]
//     never pulses; final_output and frame_count unchanged.
//   3 stage_done[2] held high throughout, stages 0/1 done after 4 cycles each
//     -> stage 2 still gets its stage_start pulse; done follows one WAIT cycle later.
//   4 FRAME_CNT_W=2; 5 frames -> frame_count 1,2,3,0,1; start during busy ignored.
//   5 CNN_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=8; stage 1 never done -> error=1 after 8
//     WAIT cycles; stage_idx=1; busy=0; next start clears error and launches stage 0.
//   6 reset asserted in WAIT of stage 2 -> all outputs 0 next cycle; no done pulse.

Source files
------------

// File: rtl/cnn_3d_stage_sequencer.sv
// cnn_3d_stage_sequencer: launches NUM_STAGES compute units in order and latches the final results.
// Optional per-stage watchdog is built in when CNN_STAGE_TIMEOUT_EN is defined.
module cnn_3d_stage_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int FC_OUTPUTS     = 2,
  parameter int FRAME_CNT_W    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int RES_W = FC_OUTPUTS * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [NUM_STAGES-1:0]  stage_start,
  input  logic [NUM_STAGES-1:0]  stage_done,
  input  logic [RES_W-1:0]       fc_result,
  output logic [RES_W-1:0]       final_output,
  output logic [IDX_W-1:0]       stage_idx,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_COMPLETE = 3'd3;
  localparam logic [2:0] S_ERROR    = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cnn_3d_stage_sequencer: NUM_STAGES and TIMEOUT_CYCLES must be >= 1");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             cur_done;
  logic             timeout;

  // Only the bit of the stage currently awaited can advance the frame.
  assign cur_done = stage_done[stage_idx];

`ifdef CNN_STAGE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer;
  logic             error_q;

  assign timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign error   = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == S_LAUNCH) begin
        timer <= '0;
      end else if (state == S_WAIT && !cur_done) begin
        timer <= timer + 1'b1;
      end
      if (state == S_WAIT && state_nxt == S_ERROR) begin
        error_q <= 1'b1;
      end else if (state == S_ERROR && state_nxt == S_LAUNCH) begin
        error_q <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = stage_idx;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_LAUNCH;
          idx_nxt   = '0;
        end
      end
      S_LAUNCH: begin
        state_nxt = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cur_done) begin
          if (stage_idx == LAST_IDX) begin
            state_nxt = S_COMPLETE;
          end else begin
            state_nxt = S_LAUNCH;
            idx_nxt   = stage_idx + 1'b1;
          end
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
      S_COMPLETE: begin
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_nxt = S_LAUNCH;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      stage_idx    <= '0;
      stage_start  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      final_output <= '0;
      frame_count  <= '0;
    end else begin
      state     <= state_nxt;
      stage_idx <= idx_nxt;
      if (state_nxt == S_LAUNCH) begin
        stage_start <= NUM_STAGES'(1) << idx_nxt;
      end else begin
        stage_start <= '0;
      end
      busy <= (state_nxt == S_LAUNCH) ||
              (state_nxt == S_WAIT) ||
              (state_nxt == S_COMPLETE);
      done <= (state == S_COMPLETE);
      if (state == S_COMPLETE) begin
        frame_count <= frame_count + 1'b1;
      end
      if (state == S_WAIT && state_nxt == S_COMPLETE) begin
        final_output <= fc_result;
      end
    end
  end

endmodule

// File: tb/tb_cnn_3d_stage_sequencer.sv
// tb_cnn_3d_stage_sequencer: directed frames checked against a frame-level model.
// Watchdog scenario is included when CNN_STAGE_TIMEOUT_EN is defined.
module tb_cnn_3d_stage_sequencer;

  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int FO  = 2;
  localparam int FCW = 2;
  localparam int TMO = 8;
  localparam int RW  = FO * DW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [N-1:0]   stage_start;
  logic [N-1:0]   stage_done = '0;
  logic [RW-1:0]  fc_result = '0;
  logic [RW-1:0]  final_output;
  logic [1:0]     stage_idx;
  logic           busy;
  logic           done;
  logic [FCW-1:0] frame_count;
  logic           error;

  always #5 clk = ~clk;

  cnn_3d_stage_sequencer #(
    .NUM_STAGES(N), .DATA_WIDTH(DW), .FC_OUTPUTS(FO),
    .FRAME_CNT_W(FCW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stage_start(stage_start), .stage_done(stage_done),
    .fc_result(fc_result), .final_output(final_output),
    .stage_idx(stage_idx), .busy(busy), .done(done),
    .frame_count(frame_count), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [N-1:0] pulses[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (|stage_start) pulses.push_back(stage_start);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stage responder: per-stage completion delay, held bits, optional abort.
  logic [N-1:0] hold = '0;
  logic [N-1:0] resp_mask = '0;
  logic         abort_req = 1'b0;
  int           arm_stage = -1;
  int           dly [N] = '{default: 0};
  int           cnt [N] = '{default: 0};

  always @(posedge clk) begin
    logic [N-1:0] d;
    logic ab;
    #3;
    d  = hold;
    ab = abort_req;
    for (int i = 0; i < N; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          d[i] = 1'b1;
          if (i == arm_stage) ab = 1'b1;
        end
      end
      if (stage_start[i] && resp_mask[i]) cnt[i] = dly[i] + 1;
    end
    stage_done = d;
    abort      = ab;
  end

  // Frame-level model: phase 0 idle, 1 launching, 2 awaiting, 3 finishing, 4 faulted.
  int           m_ph = 0;
  int           m_k = 0;
  int           m_w = 0;
  int           m_frames = 0;
  logic [RW-1:0] m_out = '0;
  bit           m_err = 0;
  bit           m_done = 0;
  bit           model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_k = 0; m_w = 0; m_frames = 0;
      m_out = '0; m_err = 0; m_done = 0; model_ok = 1;
    end else begin
      m_done = 0;
      case (m_ph)
        0: if (start && !abort) begin m_ph = 1; m_k = 0; end
        1: begin m_w = 0; m_ph = abort ? 0 : 2; end
        2: begin
          if (abort) m_ph = 0;
          else if (stage_done[m_k]) begin
            if (m_k == N - 1) begin m_ph = 3; m_out = fc_result; end
            else begin m_k++; m_ph = 1; end
          end else begin
            m_w++;
`ifdef CNN_STAGE_TIMEOUT_EN
            if (m_w == TMO) begin m_ph = 4; m_err = 1; end
`endif
          end
        end
        3: begin m_done = 1; m_frames = (m_frames + 1) % (1 << FCW); m_ph = 0; end
        4: if (start) begin m_ph = 1; m_k = 0; m_err = 0; end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("stage_start", stage_start, (m_ph == 1) ? (N'(1) << m_k) : '0);
      chk("stage_idx", stage_idx, m_k);
      chk("busy", busy, (m_ph >= 1 && m_ph <= 3));
      chk("done", done, m_done);
      chk("final_output", final_output, m_out);
      chk("frame_count", frame_count, m_frames);
      chk("error", error, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0 = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done) begin lat = cyc - t0; break; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL wait_done: no done within %0d cycles", limit);
    end
  endtask

  task automatic wait_idle(input int t0, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      if (!busy) begin lat = cyc - t0; break; end
      step();
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", limit);
    end
  endtask

  function automatic logic [15:0] pack_pulses();
    logic [15:0] pk = '0;
    foreach (pulses[i]) pk = (pk << 4) | 16'(pulses[i]);
    return pk;
  endfunction

  initial begin
    int t0, lat, ds, found;
    int exp_fc [5] = '{1, 2, 3, 0, 1};

    repeat (3) step();
    reset = 1'b0;
    chk("rst_stage_start", stage_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_final", final_output, 0);
    chk("rst_frames", frame_count, 0);
    step();

    // 1: every stage done on its first wait cycle
    fc_result = {-16'sd5, 16'sd7};
    hold = 3'b111;
    pulses.delete();
    pulse_start(t0);
    wait_done(t0, 40, lat);
    chk("t1_latency", lat, 7);
    chk("t1_pulses", pack_pulses(), 16'h0124);
    chk("t1_final", final_output, 32'hFFFB_0007);
    chk("t1_elem1", $signed(final_output[31:16]) == -5, 1);
    chk("t1_frames", frame_count, 1);
    hold = '0;
    step();

    // start together with abort in idle stays idle
    start = 1'b1; abort_req = 1'b1;
    step();
    start = 1'b0; abort_req = 1'b0;
    chk("sa_busy", busy, 0);
    step();

    // 2: abort while stage 1 reports done
    fc_result = 32'h1234_5678;
    resp_mask = 3'b111;
    dly[0] = 0; dly[1] = 2; dly[2] = 0;
    arm_stage = 1;
    ds = done_seen;
    pulses.delete();
    pulse_start(t0);
    wait_idle(t0, 40, lat);
    arm_stage = -1;
    repeat (3) step();
    chk("t2_no_done", done_seen, ds);
    chk("t2_pulses", pack_pulses(), 16'h0012);
    chk("t2_final", final_output, 32'hFFFB_0007);
    chk("t2_frames", frame_count, 1);

    // 3: stage 2 done held high from the start
    fc_result = 32'h0003_FFFE;
    resp_mask = 3'b011;
    dly[0] = 3; dly[1] = 3;
    hold = 3'b100;
    pulses.delete();
    pulse_start(t0);
    wait_done(t0, 60, lat);
    chk("t3_latency", lat, 13);
    chk("t3_pulses", pack_pulses(), 16'h0124);
    chk("t3_final", final_output, 32'h0003_FFFE);
    chk("t3_frames", frame_count, 2);
    hold = '0;
    step();

    // 6: reset while awaiting stage 2
    resp_mask = 3'b011;
    dly[0] = 0; dly[1] = 0;
    ds = done_seen;
    pulse_start(t0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (busy && stage_idx == 2 && stage_start == 0) found = 1;
      else step();
    end
    chk("t6_reached_wait2", found, 1);
    step();
    reset = 1'b1;
    step();
    chk("t6_stage_start", stage_start, 0);
    chk("t6_final", final_output, 0);
    chk("t6_idx", stage_idx, 0);
    chk("t6_frames", frame_count, 0);
    chk("t6_busy", busy, 0);
    reset = 1'b0;
    step();
    chk("t6_no_done", done_seen, ds);
    resp_mask = '0;

    // 4: back-to-back frames, counter wraps, start while busy ignored
    hold = 3'b111;
    fc_result = 32'h0001_0002;
    for (int f = 0; f < 5; f++) begin
      pulse_start(t0);
      if (f == 2) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      wait_done(t0, 40, lat);
      chk("t4_latency", lat, 7);
      chk("t4_frames", frame_count, exp_fc[f]);
    end
    hold = '0;
    repeat (12) step();
    chk("t4_no_requeue", busy, 0);

`ifdef CNN_STAGE_TIMEOUT_EN
    // 5: stage 1 never completes
    resp_mask = 3'b001;
    dly[0] = 0;
    pulse_start(t0);
    wait_idle(t0, 40, lat);
    chk("t5_latency", lat, 11);
    chk("t5_error", error, 1);
    chk("t5_idx", stage_idx, 1);
    chk("t5_busy", busy, 0);
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    step();
    chk("t5_abort_noeffect", error, 1);
    hold = 3'b111;
    resp_mask = '0;
    pulse_start(t0);
    chk("t5_cleared", error, 0);
    chk("t5_relaunch", stage_start, 3'b001);
    chk("t5_idx0", stage_idx, 0);
    wait_done(t0, 40, lat);
    chk("t5_latency2", lat, 7);
    hold = '0;
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
